// File: rtl/ecc_scrub_ram.sv
// ecc_scrub_ram: SECDED-protected single-port word RAM with host read/write
// access, error injection on writes, background scrubbing with write-back
// of corrected words, and saturating single/double error counters.
//
// Handshake: a host request transfers on a rising clk edge where
// req_valid && req_ready. req_ready is high only in IDLE with no scrub
// pending. Writes complete on the accepting edge. Reads answer with a
// one-cycle rsp_valid strobe two cycles after acceptance.
module ecc_scrub_ram #(
    parameter  int DATA_W         = 32,
    parameter  int ADDR_W         = 8,
    parameter  int SCRUB_INTERVAL = 1024,
    parameter  int CNT_W          = 16,
    // Smallest P with 2^P >= DATA_W + P + 1.
    localparam int P              = (DATA_W <= 4)   ? 3 :
                                    (DATA_W <= 11)  ? 4 :
                                    (DATA_W <= 26)  ? 5 :
                                    (DATA_W <= 57)  ? 6 :
                                    (DATA_W <= 120) ? 7 : 8,
    localparam int CW_W           = DATA_W + P + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_serr,
    output logic              rsp_derr,
    input  logic              scrub_en,
    input  logic [CW_W-1:0]   inj_mask,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  serr_cnt,
    output logic [CNT_W-1:0]  derr_cnt,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic              err_double,
    output logic              busy
);

    // Hamming positions 1..NPOS live in codeword bits 0..NPOS-1; the
    // overall parity bit sits in the MSB.
    localparam int NPOS = DATA_W + P;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int IW = $clog2(SCRUB_INTERVAL);
    localparam logic [IW-1:0]     IV_LAST   = IW'(SCRUB_INTERVAL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_READ  = 3'd2,
        S_CHECK = 3'd3,
        S_WBACK = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // SECDED helpers
    // ------------------------------------------------------------------
    function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] cw;
        logic            b;
        int              di;
        cw = '0;
        di = 0;
        for (int pos = 1; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[di];
                di++;
            end
        end
        for (int k = 0; k < P; k++) begin
            b = 1'b0;
            for (int pos = 1; pos <= NPOS; pos++) begin
                if (((pos >> k) & 1) != 0) b = b ^ cw[pos-1];
            end
            cw[(1 << k) - 1] = b;
        end
        cw[CW_W-1] = ^cw[CW_W-2:0];
        return cw;
    endfunction

    function automatic logic [P-1:0] syndrome(input logic [CW_W-1:0] cw);
        logic [P-1:0] s;
        s = '0;
        for (int pos = 1; pos <= NPOS; pos++) begin
            if (cw[pos-1]) s = s ^ P'(pos);
        end
        return s;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int                di;
        d  = '0;
        di = 0;
        for (int pos = 1; pos <= NPOS; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[di] = cw[pos-1];
                di++;
            end
        end
        return d;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW_W-1:0]   mem_q [DEPTH];

    state_t            state_q, state_d;
    logic              scrub_q, scrub_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] sptr_q, sptr_d;
    logic [IW-1:0]     ival_q, ival_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  serr_cnt_q, serr_cnt_d;
    logic [CNT_W-1:0]  derr_cnt_q, derr_cnt_d;

    logic [CW_W-1:0]   cw_q;
    logic              serr_q, derr_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_serr_q, rsp_derr_q;

    logic              launch;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [CW_W-1:0]   mem_wdata;
    logic [CW_W-1:0]   enc_zero;
    logic [CW_W-1:0]   enc_wr;

    logic [CW_W-1:0]   rd_cw;
    logic [P-1:0]      syn;
    logic              par_err;
    logic [CW_W-1:0]   dec_cw;
    logic              dec_serr, dec_derr;
    logic              serr_inc, derr_inc;

    assign enc_zero = encode('0);
    assign enc_wr   = encode(req_wdata) ^ inj_mask;

    // FSM next-state, memory write port select and scrub launch
    always_comb begin
        state_d     = state_q;
        scrub_d     = scrub_q;
        init_addr_d = init_addr_q;
        addr_d      = addr_q;
        sptr_d      = sptr_q;
        launch      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr_q;
        mem_wdata   = cw_q;
        case (state_q)
            S_INIT: begin
                mem_we      = 1'b1;
                mem_waddr   = init_addr_q;
                mem_wdata   = enc_zero;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == ADDR_LAST) state_d = S_IDLE;
            end
            S_IDLE: begin
                // A pending scrub outranks any host request this cycle.
                if (pend_q) begin
                    launch  = 1'b1;
                    scrub_d = 1'b1;
                    addr_d  = sptr_q;
                    state_d = S_READ;
                end else if (req_valid) begin
                    if (req_we) begin
                        mem_we    = 1'b1;
                        mem_waddr = req_addr;
                        mem_wdata = enc_wr;
                    end else begin
                        scrub_d = 1'b0;
                        addr_d  = req_addr;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (scrub_q) sptr_d = sptr_q + 1'b1;
                state_d = serr_q ? S_WBACK : S_IDLE;
            end
            S_WBACK: begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = cw_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Interval counter and scrub-pending flag
    always_comb begin
        ival_d = ival_q;
        pend_d = pend_q;
        if (!scrub_en) begin
            ival_d = '0;
            pend_d = 1'b0;
        end else begin
            if (launch) pend_d = 1'b0;
            if (ival_q == IV_LAST) begin
                ival_d = '0;
                pend_d = 1'b1;
            end else begin
                ival_d = ival_q + 1'b1;
            end
        end
    end

    // Decode the word being read; a syndrome pointing past the codeword
    // cannot be a single flip, so it is reported as uncorrectable.
    always_comb begin
        rd_cw    = mem_q[addr_q];
        syn      = syndrome(rd_cw);
        par_err  = ^rd_cw;
        dec_cw   = rd_cw;
        dec_serr = 1'b0;
        dec_derr = 1'b0;
        if (syn != '0) begin
            if (par_err && (int'(syn) <= NPOS)) begin
                dec_serr = 1'b1;
                for (int pos = 1; pos <= NPOS; pos++) begin
                    if (P'(pos) == syn) dec_cw[pos-1] = ~rd_cw[pos-1];
                end
            end else begin
                dec_derr = 1'b1;
            end
        end else if (par_err) begin
            dec_serr           = 1'b1;
            dec_cw[CW_W-1]     = ~rd_cw[CW_W-1];
        end
    end

    // Saturating error counters; a clear coinciding with an error leaves 1
    always_comb begin
        serr_inc   = (state_q == S_CHECK) && serr_q;
        derr_inc   = (state_q == S_CHECK) && derr_q;
        serr_cnt_d = serr_cnt_q;
        derr_cnt_d = derr_cnt_q;
        if (clr_cnt) begin
            serr_cnt_d = serr_inc ? CNT_ONE : '0;
            derr_cnt_d = derr_inc ? CNT_ONE : '0;
        end else begin
            if (serr_inc && (serr_cnt_q != CNT_MAX)) serr_cnt_d = serr_cnt_q + 1'b1;
            if (derr_inc && (derr_cnt_q != CNT_MAX)) derr_cnt_d = derr_cnt_q + 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_INIT;
            scrub_q     <= 1'b0;
            init_addr_q <= '0;
            addr_q      <= '0;
            sptr_q      <= '0;
            ival_q      <= '0;
            pend_q      <= 1'b0;
            serr_cnt_q  <= '0;
            derr_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            scrub_q     <= scrub_d;
            init_addr_q <= init_addr_d;
            addr_q      <= addr_d;
            sptr_q      <= sptr_d;
            ival_q      <= ival_d;
            pend_q      <= pend_d;
            serr_cnt_q  <= serr_cnt_d;
            derr_cnt_q  <= derr_cnt_d;
        end
    end

    // Capture decode results at the end of READ; host responses persist
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_q        <= '0;
            serr_q      <= 1'b0;
            derr_q      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_serr_q  <= 1'b0;
            rsp_derr_q  <= 1'b0;
        end else if (state_q == S_READ) begin
            cw_q   <= dec_cw;
            serr_q <= dec_serr;
            derr_q <= dec_derr;
            if (!scrub_q) begin
                rsp_rdata_q <= extract(dec_cw);
                rsp_serr_q  <= dec_serr;
                rsp_derr_q  <= dec_derr;
            end
        end
    end

    // Codeword storage (initialised by the INIT sweep, not by reset)
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign req_ready  = (state_q == S_IDLE) && !pend_q;
    assign busy       = (state_q != S_IDLE);
    assign rsp_valid  = (state_q == S_CHECK) && !scrub_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_serr   = rsp_serr_q;
    assign rsp_derr   = rsp_derr_q;
    assign err_valid  = (state_q == S_CHECK) && (serr_q || derr_q);
    assign err_addr   = err_valid ? addr_q : '0;
    assign err_double = err_valid && derr_q;
    assign serr_cnt   = serr_cnt_q;
    assign derr_cnt   = derr_cnt_q;

endmodule

// File: tb/tb_ecc_scrub_ram.sv
// Directed bench for ecc_scrub_ram: init sweep, plain read/write, single,
// parity-only and double errors, response hold, scrubbing, reset during
// write-back, counter clear and saturation.
module tb_ecc_scrub_ram;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int SI     = 64;
    localparam int CNT_W  = 2;
    localparam int CW_W   = 39;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_serr;
    logic              rsp_derr;
    logic              scrub_en;
    logic [CW_W-1:0]   inj_mask;
    logic              clr_cnt;
    logic [CNT_W-1:0]  serr_cnt;
    logic [CNT_W-1:0]  derr_cnt;
    logic              err_valid;
    logic [ADDR_W-1:0] err_addr;
    logic              err_double;
    logic              busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [DATA_W-1:0] r_rdata;
    logic              r_serr, r_derr, r_ev, r_ed, r_wb, r_got;
    logic [ADDR_W-1:0] r_ea;
    int                r_lat;

    ecc_scrub_ram #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCRUB_INTERVAL(SI), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_serr(rsp_serr), .rsp_derr(rsp_derr),
        .scrub_en(scrub_en), .inj_mask(inj_mask), .clr_cnt(clr_cnt),
        .serr_cnt(serr_cnt), .derr_cnt(derr_cnt),
        .err_valid(err_valid), .err_addr(err_addr), .err_double(err_double),
        .busy(busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        if (req_ready !== 1'b1) begin
            vec_cnt++; err_cnt++;
            $display("FAIL ready_timeout got=%b exp=1", req_ready);
        end
    endtask

    task automatic wait_init(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        vec_cnt++;
        if (n != 16) begin err_cnt++; $display("FAIL %s_init_cycles got=%0d exp=16", name, n); end
    endtask

    task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic [CW_W-1:0] m);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; inj_mask = m;
        tick();
        req_valid = 1'b0; req_we = 1'b0; inj_mask = '0;
    endtask

    task automatic host_read(input logic [ADDR_W-1:0] a, input logic clr_in_check);
        int n;
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        r_got = rsp_valid; r_lat = n;
        r_rdata = rsp_rdata; r_serr = rsp_serr; r_derr = rsp_derr;
        r_ev = err_valid; r_ea = err_addr; r_ed = err_double;
        if (r_got !== 1'b1) begin
            vec_cnt++; err_cnt++;
            $display("FAIL rsp_timeout addr=%0d got=%b exp=1", a, r_got);
        end
        clr_cnt = clr_in_check;
        tick();
        clr_cnt = 1'b0;
        r_wb = busy;
        if (r_wb === 1'b1) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL rst_busy got=%b exp=1", busy); end
        vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
        vec_cnt++; if (rsp_valid !== 1'b0 || err_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_strobes got=%b%b exp=00", rsp_valid, err_valid); end
        vec_cnt++; if (serr_cnt !== 2'd0 || derr_cnt !== 2'd0) begin err_cnt++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", serr_cnt, derr_cnt); end
        vec_cnt++; if (rsp_rdata !== 32'h0 || err_addr !== 4'd0) begin err_cnt++; $display("FAIL rst_data got=%h/%0d exp=0/0", rsp_rdata, err_addr); end
        rst = 1'b0;
        wait_init("rst");
        for (int a = 0; a < 16; a++) begin
            host_read(4'(a), 1'b0);
            vec_cnt++;
            if (r_rdata !== 32'h0 || r_serr !== 1'b0 || r_derr !== 1'b0 || r_ev !== 1'b0)
                begin err_cnt++; $display("FAIL init_read a=%0d got=%h s%b d%b e%b exp=0", a, r_rdata, r_serr, r_derr, r_ev); end
        end
    endtask

    task automatic test_write_read();
        host_write(4'd3, 32'hDEADBEEF, '0);
        host_read(4'd3, 1'b0);
        vec_cnt++; if (r_lat != 2) begin err_cnt++; $display("FAIL wr_latency got=%0d exp=2", r_lat); end
        vec_cnt++; if (r_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL wr_data got=%h exp=deadbeef", r_rdata); end
        vec_cnt++; if (r_serr !== 1'b0 || r_derr !== 1'b0 || r_ev !== 1'b0) begin err_cnt++; $display("FAIL wr_flags got=%b%b%b exp=000", r_serr, r_derr, r_ev); end
        vec_cnt++; if (r_wb !== 1'b0) begin err_cnt++; $display("FAIL wr_wback got=%b exp=0", r_wb); end
    endtask

    task automatic test_single();
        host_write(4'd5, 32'h12345678, 39'h400);
        host_read(4'd5, 1'b0);
        vec_cnt++; if (r_rdata !== 32'h12345678) begin err_cnt++; $display("FAIL se_data got=%h exp=12345678", r_rdata); end
        vec_cnt++; if (r_serr !== 1'b1 || r_derr !== 1'b0) begin err_cnt++; $display("FAIL se_flags got=%b%b exp=10", r_serr, r_derr); end
        vec_cnt++; if (r_ev !== 1'b1 || r_ea !== 4'd5 || r_ed !== 1'b0) begin err_cnt++; $display("FAIL se_err got=%b/%0d/%b exp=1/5/0", r_ev, r_ea, r_ed); end
        vec_cnt++; if (r_wb !== 1'b1) begin err_cnt++; $display("FAIL se_wback got=%b exp=1", r_wb); end
        vec_cnt++; if (serr_cnt !== 2'd1 || derr_cnt !== 2'd0) begin err_cnt++; $display("FAIL se_cnt got=%0d/%0d exp=1/0", serr_cnt, derr_cnt); end
        host_read(4'd5, 1'b0);
        vec_cnt++; if (r_rdata !== 32'h12345678 || r_serr !== 1'b0 || r_ev !== 1'b0) begin err_cnt++; $display("FAIL se_reread got=%h s%b e%b exp=12345678 s0 e0", r_rdata, r_serr, r_ev); end
        vec_cnt++; if (serr_cnt !== 2'd1) begin err_cnt++; $display("FAIL se_cnt2 got=%0d exp=1", serr_cnt); end
    endtask

    task automatic test_parity_bit();
        host_write(4'd6, 32'h0000FFFF, 39'h40_0000_0000);
        host_read(4'd6, 1'b0);
        vec_cnt++; if (r_rdata !== 32'h0000FFFF || r_serr !== 1'b1 || r_derr !== 1'b0) begin err_cnt++; $display("FAIL pb_read got=%h s%b d%b exp=0000ffff s1 d0", r_rdata, r_serr, r_derr); end
        vec_cnt++; if (serr_cnt !== 2'd2) begin err_cnt++; $display("FAIL pb_cnt got=%0d exp=2", serr_cnt); end
        host_read(4'd6, 1'b0);
        vec_cnt++; if (r_serr !== 1'b0 || r_rdata !== 32'h0000FFFF) begin err_cnt++; $display("FAIL pb_reread got=%h s%b exp=0000ffff s0", r_rdata, r_serr); end
    endtask

    task automatic test_double();
        host_write(4'd7, 32'hA5A50F0F, 39'h10_0004);
        host_read(4'd7, 1'b0);
        vec_cnt++; if (r_rdata !== 32'hA5A58F0E) begin err_cnt++; $display("FAIL de_data got=%h exp=a5a58f0e", r_rdata); end
        vec_cnt++; if (r_derr !== 1'b1 || r_serr !== 1'b0) begin err_cnt++; $display("FAIL de_flags got=%b%b exp=01", r_serr, r_derr); end
        vec_cnt++; if (r_ev !== 1'b1 || r_ea !== 4'd7 || r_ed !== 1'b1) begin err_cnt++; $display("FAIL de_err got=%b/%0d/%b exp=1/7/1", r_ev, r_ea, r_ed); end
        vec_cnt++; if (r_wb !== 1'b0) begin err_cnt++; $display("FAIL de_wback got=%b exp=0", r_wb); end
        vec_cnt++; if (derr_cnt !== 2'd1 || serr_cnt !== 2'd2) begin err_cnt++; $display("FAIL de_cnt got=%0d/%0d exp=2/1", serr_cnt, derr_cnt); end
    endtask

    task automatic test_hold();
        tick(); tick(); tick();
        host_write(4'd1, 32'hCAFEF00D, '0);
        vec_cnt++; if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL hold_wr_rsp got=%b exp=0", rsp_valid); end
        tick(); tick();
        vec_cnt++; if (rsp_rdata !== 32'hA5A58F0E || rsp_derr !== 1'b1 || rsp_serr !== 1'b0) begin err_cnt++; $display("FAIL hold_rsp got=%h s%b d%b exp=a5a58f0e s0 d1", rsp_rdata, rsp_serr, rsp_derr); end
    endtask

    task automatic test_scrub();
        int  n, rsp_seen;
        logic found, ed;
        host_write(4'd9, 32'h0BADF00D, 39'h20);
        scrub_en = 1'b1;
        n = 0; rsp_seen = 0; found = 1'b0; ed = 1'bx;
        while (!found && n < 16 * SI + 256) begin
            tick();
            n++;
            if (rsp_valid === 1'b1) rsp_seen++;
            if (err_valid === 1'b1 && err_addr === 4'd9) begin
                found = 1'b1;
                ed = err_double;
            end
        end
        scrub_en = 1'b0;
        vec_cnt++; if (found !== 1'b1) begin err_cnt++; $display("FAIL scrub_found got=%b exp=1 after %0d cycles", found, n); end
        vec_cnt++; if (ed !== 1'b0) begin err_cnt++; $display("FAIL scrub_double got=%b exp=0", ed); end
        vec_cnt++; if (rsp_seen != 0) begin err_cnt++; $display("FAIL scrub_rsp got=%0d exp=0", rsp_seen); end
        vec_cnt++; if (rsp_rdata !== 32'hA5A58F0E) begin err_cnt++; $display("FAIL scrub_hold got=%h exp=a5a58f0e", rsp_rdata); end
        host_read(4'd9, 1'b0);
        vec_cnt++; if (r_rdata !== 32'h0BADF00D || r_serr !== 1'b0 || r_derr !== 1'b0) begin err_cnt++; $display("FAIL scrub_reread got=%h s%b d%b exp=0badf00d s0 d0", r_rdata, r_serr, r_derr); end
    endtask

    task automatic test_reset_wback();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        vec_cnt++; if (serr_cnt !== 2'd0 || derr_cnt !== 2'd0) begin err_cnt++; $display("FAIL clr_plain got=%0d/%0d exp=0/0", serr_cnt, derr_cnt); end
        host_write(4'd2, 32'h55AA55AA, 39'h1);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd2;
        tick();
        req_valid = 1'b0;
        tick();
        vec_cnt++; if (rsp_valid !== 1'b1 || rsp_serr !== 1'b1 || rsp_rdata !== 32'h55AA55AA) begin err_cnt++; $display("FAIL rw_check got=v%b s%b %h exp=v1 s1 55aa55aa", rsp_valid, rsp_serr, rsp_rdata); end
        tick();
        vec_cnt++; if (busy !== 1'b1 || serr_cnt !== 2'd1) begin err_cnt++; $display("FAIL rw_wback got=b%b c%0d exp=b1 c1", busy, serr_cnt); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (busy !== 1'b1 || req_ready !== 1'b0 || err_valid !== 1'b0) begin err_cnt++; $display("FAIL rw_rst got=b%b r%b e%b exp=b1 r0 e0", busy, req_ready, err_valid); end
        vec_cnt++; if (serr_cnt !== 2'd0 || rsp_rdata !== 32'h0 || rsp_serr !== 1'b0) begin err_cnt++; $display("FAIL rw_rst_clear got=c%0d %h s%b exp=c0 0 s0", serr_cnt, rsp_rdata, rsp_serr); end
        tick(); tick();
        rst = 1'b0;
        wait_init("rw");
        host_read(4'd2, 1'b0);
        vec_cnt++; if (r_rdata !== 32'h0 || r_serr !== 1'b0 || r_derr !== 1'b0) begin err_cnt++; $display("FAIL rw_addr2 got=%h s%b d%b exp=0", r_rdata, r_serr, r_derr); end
        host_read(4'd0, 1'b0);
        vec_cnt++; if (r_rdata !== 32'h0 || r_serr !== 1'b0) begin err_cnt++; $display("FAIL rw_addr0 got=%h s%b exp=0", r_rdata, r_serr); end
    endtask

    task automatic test_clr();
        host_write(4'd4, 32'h00000001, 39'h2);
        host_read(4'd4, 1'b0);
        vec_cnt++; if (serr_cnt !== 2'd1 || r_rdata !== 32'h1) begin err_cnt++; $display("FAIL clr_pre got=c%0d %h exp=c1 1", serr_cnt, r_rdata); end
        host_write(4'd6, 32'hFFFF0000, 39'h1000);
        host_read(4'd6, 1'b1);
        vec_cnt++; if (r_serr !== 1'b1 || r_rdata !== 32'hFFFF0000) begin err_cnt++; $display("FAIL clr_read got=s%b %h exp=s1 ffff0000", r_serr, r_rdata); end
        vec_cnt++; if (serr_cnt !== 2'd1) begin err_cnt++; $display("FAIL clr_with_inc got=%0d exp=1", serr_cnt); end
    endtask

    task automatic test_saturate();
        logic [CNT_W-1:0] exp_c;
        host_write(4'd7, 32'h0, 39'h18);
        for (int i = 0; i < 4; i++) begin
            host_read(4'd7, 1'b0);
            exp_c = (i < 3) ? CNT_W'(i + 1) : 2'd3;
            vec_cnt++;
            if (derr_cnt !== exp_c || r_derr !== 1'b1 || r_rdata !== 32'h2)
                begin err_cnt++; $display("FAIL sat_%0d got=c%0d d%b %h exp=c%0d d1 00000002", i, derr_cnt, r_derr, r_rdata, exp_c); end
        end
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        scrub_en = 1'b0; inj_mask = '0; clr_cnt = 1'b0;
        #2;
        test_reset();
        test_write_read();
        test_single();
        test_parity_bit();
        test_double();
        test_hold();
        test_scrub();
        test_reset_wback();
        test_clr();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
